char_uart_tx: RTL
=================

CHAR_UART_TX -- requirements
Module: char_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10: clock cycles per serial bit, legal range 2..4095.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: character buffer entries, power of two, legal range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-high, asserted while rst_n=1.
REQ-005 SHALL have port ch_in, input, 8 bits: ASCII character from the upstream message sequencer.
REQ-006 SHALL have port ch_valid, input, 1 bit: ch_in holds a character to transfer.
REQ-007 SHALL have port ch_ready, output, 1 bit: buffer can accept a character this cycle.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high, registered.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress or the buffer is non-empty.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of buffered characters.

Function
REQ-011 SHALL transfer a character on a rising edge where ch_valid=1 and ch_ready=1, and never otherwise.
REQ-012 SHALL drive ch_ready = (fifo_count < FIFO_DEPTH), independent of ch_valid and of a same-cycle pop.
REQ-013 SHALL keep fifo_count unchanged on a simultaneous push and pop, and wrap the read and write pointers modulo FIFO_DEPTH.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, plus PARITY when enabled.
REQ-015 In IDLE with a non-empty buffer, SHALL pop the head into an 8-bit shift register and enter START on the same edge.
REQ-016 SHALL drive tx=0 in START, ch bits LSB-first in DATA, and tx=1 in STOP, each for exactly CLKS_PER_BIT cycles.
REQ-017 SHALL time every bit with a down-counter reloaded with CLKS_PER_BIT-1 at each bit boundary, and count DATA bits 0..7.
REQ-018 At the end of STOP, SHALL go directly to START if the buffer is non-empty, with no idle cycle; otherwise it SHALL enter IDLE.
REQ-019 Latency: a character pushed into an empty buffer at edge N SHALL produce tx=0 from edge N+1.
REQ-020 SHALL accept pushes during any FSM state without disturbing the frame in flight.
REQ-021 Frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.

Reset
REQ-022 While rst_n=1, SHALL force tx=1, busy=0, fifo_count=0, ch_ready=1, FSM=IDLE, and clear the counters and pointers.
REQ-023 Reset mid-frame SHALL abort the frame immediately, discard buffered characters, and after release SHALL idle with tx=1.

Configuration
REQ-024 Macro CHAR_UART_TX_PARITY_EN, when defined, SHALL insert a PARITY state between DATA and STOP, driving the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-025 Without CHAR_UART_TX_PARITY_EN, SHALL omit the PARITY state and its logic entirely, so DATA is followed directly by STOP.

Structure
REQ-026 SHALL place the FSM state enumeration and the constants for idle line level (1) and data bits (8) in shared package uart_pkg.
REQ-027 SHALL implement the buffer as sub-module char_fifo (parameter FIFO_DEPTH, signals push, pop, din, dout, count, full, empty).
REQ-028 SHALL keep the FSM, bit counter, baud counter and parity logic in char_uart_tx.

Verification
REQ-029 CLKS_PER_BIT=4, push 0x47 ('G') into an empty buffer -> tx = 0,1,1,1,0,0,0,1,0,1, each level held 4 cycles; busy drops after 40 cycles.
REQ-030 Hold ch_valid=1 for 6 consecutive cycles with 0x51, 0x51, 0x75, 0x65, 0x74, 0x7A -> 5 characters accepted (first popped at once, next four buffered); ch_ready=0 on the 6th; 0x7A is transmitted only after ch_ready rises again and is re-presented.
REQ-031 Back-to-back 0x61 then 0x6C -> the stop bit of 0x61 is followed on the next cycle by the start bit of 0x6C, with no extra idle cycles.
REQ-032 Assert rst_n=1 during DATA bit 3 with 2 characters buffered -> tx=1, fifo_count=0 and busy=0 in the same cycle; after release no frame starts.
REQ-033 With CHAR_UART_TX_PARITY_EN defined and CLKS_PER_BIT=4: 0x47 -> parity bit 0; 0x51 -> parity bit 1; each frame is 44 cycles.
REQ-034 Push and pop in the same cycle with fifo_count=2 -> fifo_count stays 2 and the character order is preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the character UART transmitter: FSM states and frame constants.
// The PARITY state exists only when CHAR_UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef CHAR_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/char_fifo.sv
// Power-of-two character FIFO; pointers wrap naturally at FIFO_DEPTH.
// Push is ignored when full and pop is ignored when empty.
module char_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/char_uart_tx.sv
// Buffered 8N1 UART transmitter fed by a character valid/ready stream.
// Define CHAR_UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module char_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  ch_in,
  input  logic                        ch_valid,
  output logic                        ch_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam logic [11:0] BIT_RELOAD = 12'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

  state_t      state_q;
  logic [11:0] baud_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;
`ifdef CHAR_UART_TX_PARITY_EN
  logic        parity_q;
`endif

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       push;
  logic       pop;
  logic       bit_done;

  assign bit_done = (baud_cnt_q == '0);
  assign push     = ch_valid && ch_ready;
  // The head is taken either from idle or at the last cycle of a stop bit.
  assign pop      = !fifo_empty &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  assign ch_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign tx       = tx_q;

  char_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ch_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= IDLE_LEVEL;
`ifdef CHAR_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      if (state_q != IDLE) begin
        baud_cnt_q <= bit_done ? BIT_RELOAD : baud_cnt_q - 1'b1;
      end
      // Loading a character drives the start bit on the same edge as the pop.
      if (pop) begin
        state_q    <= START;
        shift_q    <= fifo_dout;
        bit_idx_q  <= '0;
        baud_cnt_q <= BIT_RELOAD;
        tx_q       <= 1'b0;
`ifdef CHAR_UART_TX_PARITY_EN
        parity_q   <= ^fifo_dout;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            tx_q <= IDLE_LEVEL;
          end
          START: begin
            if (bit_done) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              tx_q      <= shift_q[0];
            end
          end
          DATA: begin
            if (bit_done) begin
              if (bit_idx_q == LAST_BIT) begin
`ifdef CHAR_UART_TX_PARITY_EN
                state_q <= PARITY;
                tx_q    <= parity_q;
`else
                state_q <= STOP;
                tx_q    <= IDLE_LEVEL;
`endif
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
                shift_q   <= {1'b0, shift_q[7:1]};
                tx_q      <= shift_q[1];
              end
            end
          end
`ifdef CHAR_UART_TX_PARITY_EN
          PARITY: begin
            if (bit_done) begin
              state_q <= STOP;
              tx_q    <= IDLE_LEVEL;
            end
          end
`endif
          STOP: begin
            if (bit_done) begin
              state_q <= IDLE;
              tx_q    <= IDLE_LEVEL;
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= IDLE_LEVEL;
          end
        endcase
      end
    end
  end

endmodule
